// File: rtl/cv32e40px_x_result_writeback.sv
// -----------------------------------------------------------------------------
// cv32e40px_x_result_writeback
//
// Purpose:
//   Buffers CORE-V-XIF coprocessor results in a small FIFO and drains them onto
//   register-file write port B. The port is yielded to the core whenever its
//   own port-B writer is active. Every entry that leaves the FIFO is reported
//   back to the scoreboard through a one-cycle retire pulse carrying its ID.
//
// Configuration macro:
//   CV32E40PX_XWB_SPLIT_EN - when defined, pair writes (we=11) are emitted as
//   two single-lane writes (rd, then rd+1) by a two-state split FSM, and
//   we_b_o[1] is always 0. When undefined, a pair issues in one cycle with
//   we_b_o=11.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   x_result_valid_i    result offered
//   x_result_ready_o    result accepted when high together with valid
//   x_result_id_i       instruction ID
//   x_result_rd_i       destination register (base register for pairs)
//   x_result_data_i     lane 0 -> rd, lane 1 -> rd+1
//   x_result_we_i       lane write enables
//   core_wb_b_busy_i    core owns port B this cycle
//   waddr_b_o           register-file write address
//   wdata_b_o           register-file write data lanes
//   we_b_o              register-file write enables
//   retire_valid_o      one-cycle pulse: an entry was fully written
//   retire_id_o         ID of the retired entry
//   err_pair_o          one-cycle pulse: pair request with odd rd
// -----------------------------------------------------------------------------
module cv32e40px_x_result_writeback #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    x_result_valid_i,
    output logic                    x_result_ready_o,
    input  logic [ID_WIDTH-1:0]     x_result_id_i,
    input  logic [ADDR_WIDTH-1:0]   x_result_rd_i,
    input  logic [2*DATA_WIDTH-1:0] x_result_data_i,
    input  logic [1:0]              x_result_we_i,
    input  logic                    core_wb_b_busy_i,
    output logic [ADDR_WIDTH-1:0]   waddr_b_o,
    output logic [2*DATA_WIDTH-1:0] wdata_b_o,
    output logic [1:0]              we_b_o,
    output logic                    retire_valid_o,
    output logic [ID_WIDTH-1:0]     retire_id_o,
    output logic                    err_pair_o
);

    localparam int              PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]  DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

    // FIFO storage (no reset needed: validity is tracked by count_q)
    logic [ID_WIDTH-1:0]     id_mem   [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]   rd_mem   [FIFO_DEPTH];
    logic [2*DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
    logic [1:0]              we_mem   [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    logic                retire_valid_q;
    logic [ID_WIDTH-1:0] retire_id_q;
    logic                err_pair_q;

    logic                    push;
    logic                    pop;
    logic                    empty;
    logic                    pair_illegal;
    logic [1:0]              we_masked;
    logic [ID_WIDTH-1:0]     head_id;
    logic [ADDR_WIDTH-1:0]   head_rd;
    logic [2*DATA_WIDTH-1:0] head_data;
    logic [1:0]              head_we;

    // Ready depends only on the registered count, so a full FIFO never
    // accepts even if the head pops in the same cycle.
    assign x_result_ready_o = (count_q < DEPTH_C);
    assign push             = x_result_valid_i & x_result_ready_o;
    assign empty            = (count_q == '0);

    // Enables are masked once at acceptance: an odd-based pair loses its
    // upper lane, and integer x0 never gets written.
    assign pair_illegal = x_result_we_i[1] & x_result_rd_i[0];
    assign we_masked[1] = x_result_we_i[1] & ~x_result_rd_i[0];
    assign we_masked[0] = x_result_we_i[0] & (x_result_rd_i != '0);

    assign head_id   = id_mem[rd_ptr_q];
    assign head_rd   = rd_mem[rd_ptr_q];
    assign head_data = data_mem[rd_ptr_q];
    assign head_we   = we_mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            id_mem[wr_ptr_q]   <= x_result_id_i;
            rd_mem[wr_ptr_q]   <= x_result_rd_i;
            data_mem[wr_ptr_q] <= x_result_data_i;
            we_mem[wr_ptr_q]   <= we_masked;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            retire_valid_q <= 1'b0;
            retire_id_q    <= '0;
            err_pair_q     <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            retire_valid_q <= pop;
            if (pop) begin
                retire_id_q <= head_id;
            end
            err_pair_q     <= push & pair_illegal;
        end
    end

    assign retire_valid_o = retire_valid_q;
    assign retire_id_o    = retire_id_q;
    assign err_pair_o     = err_pair_q;

`ifdef CV32E40PX_XWB_SPLIT_EN
    typedef enum logic {ST_FIRST, ST_SECOND} state_t;
    state_t state_q, state_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FIRST;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: only a pair leaves FIRST, and only once its first write
    // actually reaches the port.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FIRST: begin
                if (!empty && (head_we == 2'b11) && !core_wb_b_busy_i) begin
                    state_d = ST_SECOND;
                end
            end
            ST_SECOND: begin
                if (!core_wb_b_busy_i) begin
                    state_d = ST_FIRST;
                end
            end
            default: state_d = ST_FIRST;
        endcase
    end

    // Outputs: every write goes out on lane 0. The upper register (rd+1)
    // is targeted by the second half of a pair and by lane-1-only entries.
    always_comb begin
        waddr_b_o = '0;
        wdata_b_o = '0;
        we_b_o    = 2'b00;
        pop       = 1'b0;
        if (!empty) begin
            if ((head_we == 2'b10) || ((head_we == 2'b11) && (state_q == ST_SECOND))) begin
                waddr_b_o                   = head_rd + ADDR_WIDTH'(1);
                wdata_b_o[DATA_WIDTH-1:0]   = head_data[2*DATA_WIDTH-1:DATA_WIDTH];
            end else begin
                waddr_b_o                   = head_rd;
                wdata_b_o[DATA_WIDTH-1:0]   = head_data[DATA_WIDTH-1:0];
            end
            if ((head_we != 2'b00) && !core_wb_b_busy_i) begin
                we_b_o = 2'b01;
            end
            pop = (head_we == 2'b00) ||
                  (!core_wb_b_busy_i && ((head_we != 2'b11) || (state_q == ST_SECOND)));
        end
    end
`else
    // Whole entry goes out in one cycle; entries with nothing left to write
    // drain without waiting for the port.
    always_comb begin
        waddr_b_o = '0;
        wdata_b_o = '0;
        we_b_o    = 2'b00;
        pop       = 1'b0;
        if (!empty) begin
            waddr_b_o = head_rd;
            wdata_b_o = head_data;
            if (!core_wb_b_busy_i) begin
                we_b_o = head_we;
            end
            pop = (head_we == 2'b00) || !core_wb_b_busy_i;
        end
    end
`endif

endmodule

// File: tb/tb_cv32e40px_x_result_writeback.sv
// -----------------------------------------------------------------------------
// tb_cv32e40px_x_result_writeback
//
// Scoreboard bench: expected writes and retire IDs are queued when a result is
// accepted and compared when the DUT drives port B or pulses retire.
// -----------------------------------------------------------------------------
module tb_cv32e40px_x_result_writeback;

    logic        clk;
    logic        rst_n;
    logic        x_result_valid_i;
    logic        x_result_ready_o;
    logic [3:0]  x_result_id_i;
    logic [5:0]  x_result_rd_i;
    logic [63:0] x_result_data_i;
    logic [1:0]  x_result_we_i;
    logic        core_wb_b_busy_i;
    logic [5:0]  waddr_b_o;
    logic [63:0] wdata_b_o;
    logic [1:0]  we_b_o;
    logic        retire_valid_o;
    logic [3:0]  retire_id_o;
    logic        err_pair_o;

    cv32e40px_x_result_writeback dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .x_result_valid_i (x_result_valid_i),
        .x_result_ready_o (x_result_ready_o),
        .x_result_id_i    (x_result_id_i),
        .x_result_rd_i    (x_result_rd_i),
        .x_result_data_i  (x_result_data_i),
        .x_result_we_i    (x_result_we_i),
        .core_wb_b_busy_i (core_wb_b_busy_i),
        .waddr_b_o        (waddr_b_o),
        .wdata_b_o        (wdata_b_o),
        .we_b_o           (we_b_o),
        .retire_valid_o   (retire_valid_o),
        .retire_id_o      (retire_id_o),
        .err_pair_o       (err_pair_o)
    );

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  we;
    } wr_t;

    wr_t        wr_q[$];
    logic [3:0] ret_q[$];
    wr_t        mon_e;
    logic [3:0] mon_id;

    int   n_checks  = 0;
    int   n_errors  = 0;
    logic mon_en    = 1'b0;
    logic err_exp   = 1'b0;
    logic rand_busy = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs change 1 time unit after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (rand_busy) core_wb_b_busy_i = ($urandom_range(0, 3) == 0);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Offer one result, wait for acceptance, then record what must come out.
    task automatic push(input logic [3:0] id, input logic [5:0] rd, input logic [1:0] we,
                        input logic [31:0] d0, input logic [31:0] d1);
        int   n;
        logic [1:0] we_m;
        logic err;
        wr_t  w;
        x_result_valid_i = 1'b1;
        x_result_id_i    = id;
        x_result_rd_i    = rd;
        x_result_we_i    = we;
        x_result_data_i  = {d1, d0};
        n = 0;
        while (!x_result_ready_o && n < 100) begin
            step();
            n++;
        end
        if (n == 100) begin
            check_eq("push_timeout", 64'd1, 64'd0);
            x_result_valid_i = 1'b0;
            return;
        end
        step();
        x_result_valid_i = 1'b0;
        $display("push id=%0h rd=%0d we=%b d0=%h d1=%h", id, rd, we, d0, d1);
        we_m = we;
        err  = we[1] & rd[0];
        if (err) we_m[1] = 1'b0;
        if (rd == 6'd0) we_m[0] = 1'b0;
        err_exp = err;
`ifdef CV32E40PX_XWB_SPLIT_EN
        if (we_m[0]) begin
            w.addr = rd; w.d0 = d0; w.d1 = 32'h0; w.we = 2'b01;
            wr_q.push_back(w);
        end
        if (we_m[1]) begin
            w.addr = rd + 6'd1; w.d0 = d1; w.d1 = 32'h0; w.we = 2'b01;
            wr_q.push_back(w);
        end
`else
        if (we_m != 2'b00) begin
            w.addr = rd; w.d0 = d0; w.d1 = d1; w.we = we_m;
            wr_q.push_back(w);
        end
`endif
        ret_q.push_back(id);
    endtask

    // Scoreboard side: compare port-B writes, retire pulses and error pulses.
    always @(negedge clk) begin
        if (mon_en) begin
            if (we_b_o != 2'b00) begin
                if (wr_q.size() == 0) begin
                    check_eq("write_unexpected", {62'd0, we_b_o}, 64'd0);
                end else begin
                    mon_e = wr_q.pop_front();
                    check_eq("wr_we", {62'd0, we_b_o}, {62'd0, mon_e.we});
                    check_eq("wr_addr", {58'd0, waddr_b_o}, {58'd0, mon_e.addr});
                    if (mon_e.we[0]) check_eq("wr_lane0", {32'd0, wdata_b_o[31:0]}, {32'd0, mon_e.d0});
                    if (mon_e.we[1]) check_eq("wr_lane1", {32'd0, wdata_b_o[63:32]}, {32'd0, mon_e.d1});
                end
            end
            if (retire_valid_o) begin
                $display("retire id=%0h", retire_id_o);
                if (ret_q.size() == 0) begin
                    check_eq("retire_unexpected", 64'd1, 64'd0);
                end else begin
                    mon_id = ret_q.pop_front();
                    check_eq("retire_id", {60'd0, retire_id_o}, {60'd0, mon_id});
                end
            end
            check_eq("err_pair", {63'd0, err_pair_o}, {63'd0, err_exp});
        end
        err_exp = 1'b0;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n            = 1'b0;
        x_result_valid_i = 1'b0;
        x_result_id_i    = '0;
        x_result_rd_i    = '0;
        x_result_data_i  = '0;
        x_result_we_i    = '0;
        core_wb_b_busy_i = 1'b0;

        // Reset state
        cycles(3);
        check_eq("rst_we", {62'd0, we_b_o}, 64'd0);
        check_eq("rst_waddr", {58'd0, waddr_b_o}, 64'd0);
        check_eq("rst_wdata", wdata_b_o, 64'd0);
        check_eq("rst_retire_valid", {63'd0, retire_valid_o}, 64'd0);
        check_eq("rst_retire_id", {60'd0, retire_id_o}, 64'd0);
        check_eq("rst_err", {63'd0, err_pair_o}, 64'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        step();
        check_eq("rst_ready", {63'd0, x_result_ready_o}, 64'd1);

        // Single write: drive next cycle, retire the cycle after
        push(4'd1, 6'd5, 2'b01, 32'hDEADBEEF, 32'h0);
        check_eq("single_we", {62'd0, we_b_o}, 64'd1);
        check_eq("single_waddr", {58'd0, waddr_b_o}, 64'd5);
        check_eq("single_wdata0", {32'd0, wdata_b_o[31:0]}, 64'hDEADBEEF);
        step();
        check_eq("single_retire_valid", {63'd0, retire_valid_o}, 64'd1);
        check_eq("single_retire_id", {60'd0, retire_id_o}, 64'd1);
        cycles(2);

        // Backpressure: core owns port B while two results arrive
        core_wb_b_busy_i = 1'b1;
        push(4'd2, 6'd10, 2'b01, 32'h0000_0A0A, 32'h0);
        push(4'd3, 6'd11, 2'b01, 32'h0000_0B0B, 32'h0);
        check_eq("bp_ready_full", {63'd0, x_result_ready_o}, 64'd0);
        check_eq("bp_we_busy", {62'd0, we_b_o}, 64'd0);
        step();
        check_eq("bp_we_busy2", {62'd0, we_b_o}, 64'd0);
        core_wb_b_busy_i = 1'b0;
        #1;
        check_eq("bp_first_addr", {58'd0, waddr_b_o}, 64'd10);
        step();
        check_eq("bp_second_addr", {58'd0, waddr_b_o}, 64'd11);
        cycles(3);

        // Pair write
        push(4'd4, 6'd8, 2'b11, 32'h11, 32'h22);
`ifdef CV32E40PX_XWB_SPLIT_EN
        check_eq("pair_we", {62'd0, we_b_o}, 64'd1);
        check_eq("pair_waddr", {58'd0, waddr_b_o}, 64'd8);
        step();
        check_eq("pair_waddr_hi", {58'd0, waddr_b_o}, 64'd9);
        check_eq("pair_wdata_hi", {32'd0, wdata_b_o[31:0]}, 64'h22);
`else
        check_eq("pair_we", {62'd0, we_b_o}, 64'd3);
        check_eq("pair_waddr", {58'd0, waddr_b_o}, 64'd8);
        check_eq("pair_wdata", wdata_b_o, {32'h22, 32'h11});
`endif
        cycles(3);

        // Illegal pair on an odd base register
        push(4'd5, 6'd7, 2'b11, 32'h11, 32'h22);
        check_eq("illegal_err", {63'd0, err_pair_o}, 64'd1);
        check_eq("illegal_we", {62'd0, we_b_o}, 64'd1);
        check_eq("illegal_waddr", {58'd0, waddr_b_o}, 64'd7);
        cycles(3);

        // x0 write and empty write both drain while the port is busy
        core_wb_b_busy_i = 1'b1;
        push(4'd6, 6'd0, 2'b01, 32'h1234_5678, 32'h0);
        push(4'd7, 6'd3, 2'b00, 32'h9999_9999, 32'h0);
        cycles(3);
        check_eq("x0_empty_retired", ret_q.size(), 64'd0);
        core_wb_b_busy_i = 1'b0;
        cycles(2);

        // Random traffic with random port contention
        rand_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            push(4'(i), 6'($urandom), 2'($urandom), $urandom, $urandom);
        end
        rand_busy        = 1'b0;
        core_wb_b_busy_i = 1'b0;
        cycles(10);
        check_eq("rand_drain_wr", wr_q.size(), 64'd0);
        check_eq("rand_drain_ret", ret_q.size(), 64'd0);

        // Reset while two entries are buffered
        core_wb_b_busy_i = 1'b1;
        push(4'd8, 6'd2, 2'b11, 32'hA0A0_A0A0, 32'hA1A1_A1A1);
        push(4'd9, 6'd4, 2'b01, 32'hB0B0_B0B0, 32'h0);
        check_eq("mid_ready_full", {63'd0, x_result_ready_o}, 64'd0);
`ifdef CV32E40PX_XWB_SPLIT_EN
        core_wb_b_busy_i = 1'b0;
        step();
        core_wb_b_busy_i = 1'b1;
        #1;
        check_eq("mid_second_addr", {58'd0, waddr_b_o}, 64'd3);
        check_eq("mid_second_we", {62'd0, we_b_o}, 64'd0);
`endif
        #1;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_eq("arst_we", {62'd0, we_b_o}, 64'd0);
        check_eq("arst_waddr", {58'd0, waddr_b_o}, 64'd0);
        check_eq("arst_wdata", wdata_b_o, 64'd0);
        check_eq("arst_retire_valid", {63'd0, retire_valid_o}, 64'd0);
        check_eq("arst_retire_id", {60'd0, retire_id_o}, 64'd0);
        check_eq("arst_err", {63'd0, err_pair_o}, 64'd0);
        wr_q.delete();
        ret_q.delete();
        err_exp = 1'b0;
        cycles(2);
        #2;
        rst_n            = 1'b1;
        core_wb_b_busy_i = 1'b0;
        mon_en           = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("post_rst_ready", {63'd0, x_result_ready_o}, 64'd1);
            check_eq("post_rst_retire", {63'd0, retire_valid_o}, 64'd0);
            check_eq("post_rst_we", {62'd0, we_b_o}, 64'd0);
        end

        // FIFO still works after the reset
        push(4'd10, 6'd9, 2'b01, 32'hCAFE_F00D, 32'h0);
        cycles(3);
        check_eq("final_drain_wr", wr_q.size(), 64'd0);
        check_eq("final_drain_ret", ret_q.size(), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
